// File: rtl/lemmings_ctrl_if.sv
// Lemming controller sense/status bundle; the controller takes the slave side.
interface lemmings_ctrl_if;
  logic bump_left;
  logic bump_right;
  logic ground;
  logic dig;
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic digging;
  logic splat;

  modport master (
    output bump_left, bump_right, ground, dig,
    input  walk_left, walk_right, aaah, digging, splat
  );

  modport slave (
    input  bump_left, bump_right, ground, dig,
    output walk_left, walk_right, aaah, digging, splat
  );
endinterface

// File: rtl/lemmings_ctrl.sv
// Single-lemming Moore controller: walk/fall/dig/splat with saturating fall counter.
// Latency: outputs follow the sampled inputs by one cycle; no backpressure.
module lemmings_ctrl #(
  parameter int SPLAT_CYCLES = 20,
  parameter bit DIG_EN       = 1'b1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  lemmings_ctrl_if.slave lem
);
  localparam int CNT_W = $clog2(SPLAT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SPLAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] SPLAT_TH = CNT_W'(SPLAT_CYCLES);

  typedef enum logic [2:0] {
    WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fall_cnt, fall_cnt_nxt;
  logic             dig_req;
  logic             in_fall, to_fall;

  assign dig_req = DIG_EN & lem.dig;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= WALK_L;
      fall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fall_cnt <= fall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WALK_L: begin
        if (!lem.ground)        state_nxt = FALL_L;
        else if (dig_req)       state_nxt = DIG_L;
        else if (lem.bump_left) state_nxt = WALK_R;
      end
      WALK_R: begin
        if (!lem.ground)         state_nxt = FALL_R;
        else if (dig_req)        state_nxt = DIG_R;
        else if (lem.bump_right) state_nxt = WALK_L;
      end
      // fall_cnt lags the fall length by one, so >= threshold means N > SPLAT_CYCLES
      FALL_L: if (lem.ground) state_nxt = (fall_cnt >= SPLAT_TH) ? SPLAT : WALK_L;
      FALL_R: if (lem.ground) state_nxt = (fall_cnt >= SPLAT_TH) ? SPLAT : WALK_R;
      DIG_L:  if (!lem.ground) state_nxt = FALL_L;
      DIG_R:  if (!lem.ground) state_nxt = FALL_R;
      SPLAT:  state_nxt = SPLAT;
      default: state_nxt = WALK_L;
    endcase
  end

  assign in_fall = (state == FALL_L) || (state == FALL_R);
  assign to_fall = (state_nxt == FALL_L) || (state_nxt == FALL_R);

  always_comb begin
    fall_cnt_nxt = '0;
    if (in_fall && to_fall)
      fall_cnt_nxt = (fall_cnt == CNT_MAX) ? fall_cnt : fall_cnt + CNT_W'(1);
  end

  assign lem.walk_left  = (state == WALK_L);
  assign lem.walk_right = (state == WALK_R);
  assign lem.aaah       = in_fall;
  assign lem.digging    = (state == DIG_L) || (state == DIG_R);
  assign lem.splat      = (state == SPLAT);
endmodule

// File: tb/tb_lemmings_ctrl.sv
// Directed bench for lemmings_ctrl: default build plus a DIG_EN=0 build.
module tb_lemmings_ctrl;
  localparam logic [4:0] WL = 5'b10000;
  localparam logic [4:0] WR = 5'b01000;
  localparam logic [4:0] AA = 5'b00100;
  localparam logic [4:0] DG = 5'b00010;
  localparam logic [4:0] SP = 5'b00001;

  logic sys_clk;
  logic sys_rst;
  int   n_cmp;
  int   n_err;

  lemmings_ctrl_if lem ();
  lemmings_ctrl_if lem2 ();

  lemmings_ctrl #(.SPLAT_CYCLES(20), .DIG_EN(1'b1)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .lem     (lem)
  );

  lemmings_ctrl #(.SPLAT_CYCLES(20), .DIG_EN(1'b0)) dut_nodig (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .lem     (lem2)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [4:0] o1();
    return {lem.walk_left, lem.walk_right, lem.aaah, lem.digging, lem.splat};
  endfunction

  function automatic logic [4:0] o2();
    return {lem2.walk_left, lem2.walk_right, lem2.aaah, lem2.digging, lem2.splat};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Hold FALL for n cycles, landing sampled in the n-th; bump/dig pulses sprinkled in.
  task automatic do_fall(input int n, input string tag);
    lem.ground = 1'b0;
    tick();
    for (int i = 1; i < n; i++) begin
      chk(tag, o1(), AA);
      lem.bump_left  = (i == 5);
      lem.bump_right = (i == 7);
      lem.dig        = (i == 3);
      tick();
    end
    lem.bump_left  = 1'b0;
    lem.bump_right = 1'b0;
    lem.dig        = 1'b0;
    chk(tag, o1(), AA);
    chk_cnt({tag, "_cnt"}, int'(dut.fall_cnt), (n - 1 > 21) ? 21 : n - 1);
    lem.ground = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sys_rst = 1'b1;
    lem.bump_left = 1'b0;  lem.bump_right = 1'b0;  lem.ground = 1'b1;  lem.dig = 1'b0;
    lem2.bump_left = 1'b0; lem2.bump_right = 1'b0; lem2.ground = 1'b1; lem2.dig = 1'b0;

    tick();
    tick();
    chk("reset_out", o1(), WL);
    chk_cnt("reset_cnt", int'(dut.fall_cnt), 0);
    chk("reset_out2", o2(), WL);
    sys_rst = 1'b0;
    tick();
    chk("walk_hold", o1(), WL);

    // bump sequence (left,right): 01, 10, 01, 11
    lem.bump_right = 1'b1;                      tick(); chk("bump_01_a", o1(), WL);
    lem.bump_left = 1'b1; lem.bump_right = 1'b0; tick(); chk("bump_10",   o1(), WR);
    lem.bump_left = 1'b0; lem.bump_right = 1'b1; tick(); chk("bump_01_b", o1(), WL);
    lem.bump_left = 1'b1; lem.bump_right = 1'b1; tick(); chk("bump_11",   o1(), WR);
    lem.bump_left = 1'b0; lem.bump_right = 1'b0;

    do_fall(20, "fall20_r");
    chk("land20_r", o1(), WR);

    lem.bump_right = 1'b1; tick(); lem.bump_right = 1'b0;
    chk("turn_l", o1(), WL);
    do_fall(21, "fall21_l");
    chk("splat21", o1(), SP);
    lem.bump_left = 1'b1; lem.bump_right = 1'b1; lem.dig = 1'b1; lem.ground = 1'b0;
    tick(); chk("splat_abs_a", o1(), SP);
    lem.bump_left = 1'b0; lem.bump_right = 1'b0; lem.dig = 1'b0; lem.ground = 1'b1;
    tick(); chk("splat_abs_b", o1(), SP);
    chk_cnt("splat_cnt", int'(dut.fall_cnt), 0);
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    chk("splat_reset", o1(), WL);

    // dig left with a simultaneous bump: dig wins, direction kept
    lem.dig = 1'b1; lem.bump_left = 1'b1;
    tick(); chk("dig_l", o1(), DG);
    lem.bump_left = 1'b0; lem.bump_right = 1'b1;
    tick(); chk("dig_l_hold", o1(), DG);
    lem.dig = 1'b0; lem.bump_right = 1'b0; lem.ground = 1'b0;
    tick(); chk("dig_fall_1", o1(), AA);
    tick(); chk("dig_fall_2", o1(), AA);
    tick(); chk("dig_fall_3", o1(), AA);
    lem.ground = 1'b1;
    tick(); chk("dig_land_l", o1(), WL);
    lem.ground = 1'b0; lem.dig = 1'b1;
    tick(); chk("fall_beats_dig", o1(), AA);
    lem.ground = 1'b1; lem.dig = 1'b0;
    tick(); chk("fbd_land", o1(), WL);

    // dig right keeps the right direction through the fall
    lem.bump_left = 1'b1; tick(); lem.bump_left = 1'b0;
    chk("to_r", o1(), WR);
    lem.dig = 1'b1; tick(); lem.dig = 1'b0;
    chk("dig_r", o1(), DG);
    lem.ground = 1'b0; tick(); chk("dig_r_fall", o1(), AA);
    lem.ground = 1'b1; tick(); chk("dig_r_land", o1(), WR);

    do_fall(200, "fall200");
    chk("splat200", o1(), SP);
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    chk("rst_after200", o1(), WL);

    // reset in the 10th fall cycle
    lem.ground = 1'b0;
    tick();
    for (int i = 1; i < 10; i++) tick();
    chk("midfall_aaah", o1(), AA);
    chk_cnt("midfall_cnt9", int'(dut.fall_cnt), 9);
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    chk("midfall_rst", o1(), WL);
    chk_cnt("midfall_rst_cnt", int'(dut.fall_cnt), 0);
    lem.ground = 1'b1; tick();
    chk("post_rst_walk", o1(), WL);
    do_fall(20, "fall20_l");
    chk("land20_l", o1(), WL);

    // DIG_EN=0 build: dig is ignored
    lem2.bump_left = 1'b1; tick(); lem2.bump_left = 1'b0;
    chk("nodig_to_r", o2(), WR);
    lem2.dig = 1'b1;
    tick(); chk("nodig_a", o2(), WR);
    tick(); chk("nodig_b", o2(), WR);
    lem2.ground = 1'b0;
    tick(); chk("nodig_fall", o2(), AA);
    lem2.ground = 1'b1; lem2.dig = 1'b0;
    tick(); chk("nodig_land", o2(), WR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  always @(negedge sys_clk) begin
    if (!sys_rst && lem2.digging) begin
      n_err++;
      $error("FAIL nodig_digging observed=1 expected=0");
    end
  end
endmodule
